// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the time-shared 4-bit ALU controller:
// op codes, FSM states and the supported requester count.
package alu_share_ctrl_pkg;

   localparam int NUM_REQ_MAX = 4;

   typedef enum logic [2:0] {
      ALU_INC   = 3'b000,
      ALU_ADD   = 3'b001,
      ALU_ADD4  = 3'b010,
      ALU_ORXOR = 3'b011,
      ALU_NZ    = 3'b100,
      ALU_SHL   = 3'b101,
      ALU_SHR   = 3'b110,
      ALU_MUL   = 3'b111
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

endpackage

// File: rtl/alu_share_rr_arb.sv
// Combinational round-robin picker: one-hot grant to the first valid
// requester found scanning upward from ptr_i with wrap-around.
module alu_share_rr_arb #(
   parameter int N  = 2,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  valid_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o
);

   logic found;
   int   idx;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin time-sharing of one 4-bit ALU among NUM_REQ requesters,
// each with a private 8-bit accumulator that supplies operand B.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [3*NUM_REQ-1:0] req_func,
   input  logic [4*NUM_REQ-1:0] req_a,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   req_done,
   input  logic [NUM_REQ-1:0]   clr,
   output logic [8*NUM_REQ-1:0] acc,
   output logic                 busy
);

   localparam int PW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_param
      $error("alu_share_ctrl: NUM_REQ out of supported range");
   end

   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      owner_q, owner_d;
   alu_op_e            func_q, func_d;
   logic [3:0]         a_q, a_d;
   logic [7:0]         acc_q [NUM_REQ];
   logic [7:0]         acc_d [NUM_REQ];
   logic [NUM_REQ-1:0] done_q, done_d;

   logic [NUM_REQ-1:0] grant;
   logic [PW-1:0]      grant_idx;
   logic [2:0]         grant_func;
   logic [3:0]         grant_a;
   logic [3:0]         b_op;
   logic [7:0]         result;

   alu_share_rr_arb #(.N(NUM_REQ), .PW(PW)) u_arb (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant)
   );

   always_comb begin
      grant_idx  = '0;
      grant_func = '0;
      grant_a    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx  = PW'(i);
            grant_func = req_func[3*i +: 3];
            grant_a    = req_a[4*i +: 4];
         end
      end
   end

   // B is read live from the owner's accumulator during EXEC.
   assign b_op = acc_q[owner_q][3:0];

   always_comb begin
      result = '0;
      case (func_q)
         ALU_INC:   result = {3'b000, {1'b0, a_q} + 5'd1};
         ALU_ADD:   result = {3'b000, {1'b0, a_q} + {1'b0, b_op}};
         ALU_ADD4:  result = {4'b0000, a_q + b_op};
         ALU_ORXOR: result = {a_q | b_op, a_q ^ b_op};
         ALU_NZ:    result = {7'd0, |(a_q | b_op)};
         ALU_SHL:   result = (a_q >= 4'd8) ? 8'h00 : ({4'b0000, b_op} << a_q);
         ALU_SHR:   result = {4'b0000, b_op} >> a_q;
         ALU_MUL:   result = {4'b0000, a_q} * {4'b0000, b_op};
         default:   result = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      func_d    = func_q;
      a_d       = a_q;
      done_d    = '0;
      req_ready = '0;
      busy      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         acc_d[i] = acc_q[i];
      end
      case (state_q)
         ST_IDLE: begin
            req_ready = reset_n ? grant : '0;
            if (|grant) begin
               owner_d = grant_idx;
               func_d  = alu_op_e'(grant_func);
               a_d     = grant_a;
               ptr_d   = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (owner_q == PW'(i)) begin
                  acc_d[i]  = result;
                  done_d[i] = 1'b1;
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Clear takes priority over a coinciding write-back.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (clr[i]) acc_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         func_q  <= ALU_INC;
         a_q     <= '0;
         done_q  <= '0;
         for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         func_q  <= func_d;
         a_q     <= a_d;
         done_q  <= done_d;
         for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= acc_d[i];
      end
   end

   assign req_done = done_q;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_acc_out
      assign acc[8*g +: 8] = acc_q[g];
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl with two requesters; expected
// values are hand-computed from the ALU op table.
module tb_alu_share_ctrl;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] req_valid;
   logic [3*N-1:0] req_func;
   logic [4*N-1:0] req_a;
   logic [N-1:0] req_ready;
   logic [N-1:0] req_done;
   logic [N-1:0] clr;
   logic [8*N-1:0] acc;
   logic         busy;

   int checks = 0;
   int passed = 0;

   alu_share_ctrl #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_func  (req_func),
      .req_a     (req_a),
      .req_ready (req_ready),
      .req_done  (req_done),
      .clr       (clr),
      .acc       (acc),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      clr       = '0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Present an op, wait (bounded) for its grant, then return in EXEC.
   task automatic issue(input int idx, input logic [2:0] f, input logic [3:0] a);
      int waited;
      waited = 0;
      req_func[3*idx +: 3] = f;
      req_a[4*idx +: 4]    = a;
      req_valid[idx]       = 1'b1;
      #1;
      while (!req_ready[idx] && waited < 20) begin
         step();
         waited++;
      end
      checks++;
      if (!req_ready[idx]) $display("FAIL grant_wait req%0d ready=0 required 1", idx);
      else passed++;
      step();
      req_valid[idx] = 1'b0;
   endtask

   task automatic clear(input logic [N-1:0] m);
      clr = m;
      step();
      clr = '0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      req_func  = '0;
      req_a     = '0;
      clr       = '0;
      step();
      step();
      checks++;
      if (acc !== 16'h0000) $display("FAIL reset_acc got %h required 0000", acc); else passed++;
      checks++;
      if (req_ready !== 2'b00) $display("FAIL reset_ready got %b required 00", req_ready); else passed++;
      checks++;
      if (req_done !== 2'b00) $display("FAIL reset_done got %b required 00", req_done); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else passed++;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_add_mul_orxor();
      issue(0, 3'b001, 4'h9);
      checks++;
      if (busy !== 1'b1) $display("FAIL exec_busy got %b required 1", busy); else passed++;
      step();
      checks++;
      if (acc[7:0] !== 8'h09) $display("FAIL add_acc0 got %h required 09", acc[7:0]); else passed++;
      checks++;
      if (req_done !== 2'b01) $display("FAIL add_done got %b required 01", req_done); else passed++;
      checks++;
      if (acc[15:8] !== 8'h00) $display("FAIL add_acc1 got %h required 00", acc[15:8]); else passed++;
      step();
      checks++;
      if (req_done !== 2'b00) $display("FAIL add_done_once got %b required 00", req_done); else passed++;

      issue(0, 3'b111, 4'h3);
      step();
      checks++;
      if (acc[7:0] !== 8'h1B) $display("FAIL mul_acc0 got %h required 1b", acc[7:0]); else passed++;

      clear(2'b01);
      checks++;
      if (acc[7:0] !== 8'h00) $display("FAIL clr_acc0 got %h required 00", acc[7:0]); else passed++;
      issue(0, 3'b001, 4'h6);
      step();
      issue(0, 3'b011, 4'hA);
      step();
      checks++;
      if (acc[7:0] !== 8'hEC) $display("FAIL orxor_acc0 got %h required ec", acc[7:0]); else passed++;
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp_g;
      apply_reset();
      req_func  = {3'b000, 3'b000};
      req_a     = {4'h2, 4'h1};
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 6; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if (req_ready !== exp_g) $display("FAIL rr_grant_%0d got %b required %b", k, req_ready, exp_g);
         else passed++;
         step();
         checks++;
         if (req_ready !== 2'b00) $display("FAIL rr_exec_ready_%0d got %b required 00", k, req_ready);
         else passed++;
         step();
         checks++;
         if (req_done !== exp_g) $display("FAIL rr_done_%0d got %b required %b", k, req_done, exp_g);
         else passed++;
      end
      req_valid = '0;
      checks++;
      if (acc !== 16'h0302) $display("FAIL rr_acc got %h required 0302", acc); else passed++;
      step();
   endtask

   task automatic test_shift();
      clear(2'b01);
      issue(0, 3'b001, 4'h5);
      step();
      issue(0, 3'b101, 4'h2);
      step();
      checks++;
      if (acc[7:0] !== 8'h14) $display("FAIL shl2_acc0 got %h required 14", acc[7:0]); else passed++;
      issue(0, 3'b101, 4'h9);
      step();
      checks++;
      if (acc[7:0] !== 8'h00) $display("FAIL shl9_acc0 got %h required 00", acc[7:0]); else passed++;
      issue(0, 3'b001, 4'h5);
      step();
      issue(0, 3'b110, 4'h1);
      step();
      checks++;
      if (acc[7:0] !== 8'h02) $display("FAIL shr1_acc0 got %h required 02", acc[7:0]); else passed++;
      issue(0, 3'b000, 4'hF);
      step();
      checks++;
      if (acc[7:0] !== 8'h10) $display("FAIL incF_acc0 got %h required 10", acc[7:0]); else passed++;
      checks++;
      if (acc[15:8] !== 8'h03) $display("FAIL shift_acc1_kept got %h required 03", acc[15:8]); else passed++;
   endtask

   task automatic test_clr_writeback();
      clear(2'b11);
      issue(1, 3'b001, 4'h7);
      step();
      issue(0, 3'b001, 4'h3);
      step();
      issue(0, 3'b111, 4'h2);
      clr = 2'b11;
      step();
      clr = '0;
      checks++;
      if (acc !== 16'h0000) $display("FAIL clr_wb_acc got %h required 0000", acc); else passed++;
      checks++;
      if (req_done !== 2'b01) $display("FAIL clr_wb_done got %b required 01", req_done); else passed++;

      issue(1, 3'b001, 4'h7);
      step();
      issue(0, 3'b001, 4'h4);
      step();
      issue(0, 3'b001, 4'h1);
      clr = 2'b10;
      step();
      clr = '0;
      checks++;
      if (acc !== 16'h0005) $display("FAIL clr1_only_acc got %h required 0005", acc); else passed++;
      checks++;
      if (req_done !== 2'b01) $display("FAIL clr1_only_done got %b required 01", req_done); else passed++;
   endtask

   task automatic test_reset_in_exec();
      issue(1, 3'b001, 4'h7);
      step();
      issue(0, 3'b001, 4'h5);
      reset_n = 1'b0;
      step();
      checks++;
      if (req_done !== 2'b00) $display("FAIL rst_exec_done got %b required 00", req_done); else passed++;
      checks++;
      if (acc !== 16'h0000) $display("FAIL rst_exec_acc got %h required 0000", acc); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL rst_exec_busy got %b required 0", busy); else passed++;
      reset_n = 1'b1;
      step();
      checks++;
      if (req_done !== 2'b00) $display("FAIL rst_exec_done_late got %b required 00", req_done); else passed++;
      req_func  = {3'b000, 3'b000};
      req_a     = '0;
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) $display("FAIL rst_exec_ptr got %b required 01", req_ready); else passed++;
      req_valid = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_add_mul_orxor();
      test_fairness();
      test_shift();
      test_clr_writeback();
      test_reset_in_exec();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
